video_out_hmag: RTL and testbench

VIDEO_OUT_HMAG -- requirements
Module: video_out_hmag

---
 rtl/video_out_hmag.sv | 177 +++++++++++++++++
 tb/tb_video_out_hmag.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/video_out_hmag.sv
// Horizontal magnifier: buffers one 6-bit RGB line, then re-samples the previous
// line with a linear phase accumulator and a 2-tap blend into 8-bit output pixels.
module video_out_hmag #(
  parameter int SRC_START = 256,
  parameter int OUT_START = 200,
  parameter int OUT_WIDTH = 576,
  parameter int STEP      = 144
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [10:0] vdp_hcounter,
  input  logic [1:0]  vdp_vcounter,
  input  logic [5:0]  vdp_r,
  input  logic [5:0]  vdp_g,
  input  logic [5:0]  vdp_b,
  output logic [7:0]  video_r,
  output logic [7:0]  video_g,
  output logic [7:0]  video_b,
  input  logic [7:0]  reg_left_offset,
  input  logic [7:0]  reg_denominator,
  input  logic [5:0]  reg_normalize
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam logic [10:0] LINE_START = 11'(OUT_START - 2);
  localparam logic [11:0] WR_LO      = 12'(SRC_START);
  localparam logic [11:0] WR_HI      = 12'(SRC_START + 1024);
  localparam logic [9:0]  LAST_PIX   = 10'(OUT_WIDTH - 1);
  localparam logic [8:0]  STEP_W     = 9'(STEP);

  // {bank, index}; bank = line parity
  logic [17:0] line_mem [0:1023];

  logic        wr_en;
  logic [11:0] wr_off;
  logic [9:0]  wr_addr;

  logic unused_vcnt_hi;
  assign unused_vcnt_hi = vdp_vcounter[1];

  always_comb begin
    wr_off  = {1'b0, vdp_hcounter} - WR_LO;
    wr_en   = enable && ({1'b0, vdp_hcounter} >= WR_LO) && ({1'b0, vdp_hcounter} < WR_HI);
    wr_addr = {vdp_vcounter[0], 9'(wr_off >> 1)};
  end

  always_ff @(posedge clk) begin
    if (wr_en) line_mem[wr_addr] <= {vdp_r, vdp_g, vdp_b};
  end

  // Phase accumulator / pixel sequencer
  state_t      state_q, state_d;
  logic [9:0]  idx_q, idx_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [7:0]  frac_q, frac_d;
  logic [7:0]  den_q, den_d;
  logic [5:0]  norm_q, norm_d;
  logic [8:0]  frac_sum;
  logic        issue;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    frac_d   = frac_q;
    den_d    = den_q;
    norm_d   = norm_q;
    issue    = 1'b0;
    frac_sum = {1'b0, frac_q} + STEP_W;
    if (enable) begin
      if (vdp_hcounter == LINE_START) begin
        state_d = ST_RUN;
        idx_d   = {2'b00, reg_left_offset};
        frac_d  = '0;
        cnt_d   = '0;
        den_d   = reg_denominator;
        norm_d  = reg_normalize;
      end else if (state_q == ST_RUN) begin
        issue = 1'b1;
        cnt_d = cnt_q + 10'd1;
        // STEP never exceeds the denominator, so one subtraction keeps frac < den
        if (frac_sum >= {1'b0, den_q}) begin
          frac_d = 8'(frac_sum - {1'b0, den_q});
          idx_d  = idx_q + 10'd1;
        end else begin
          frac_d = frac_sum[7:0];
        end
        if (cnt_q == LAST_PIX) state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      frac_q  <= '0;
      den_q   <= '0;
      norm_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      frac_q  <= frac_d;
      den_q   <= den_d;
      norm_q  <= norm_d;
    end
  end

  // Fetch stage: registered buffer reads, out-of-range flags, weight
  logic        rd_bank;
  logic [9:0]  idx_b;
  logic [13:0] w_prod;
  logic [5:0]  w_cur;

  always_comb begin
    rd_bank = ~vdp_vcounter[0];
    idx_b   = idx_q + 10'd1;
    w_prod  = {6'd0, frac_q} * {8'd0, norm_q};
    w_cur   = 6'(w_prod >> 7);
  end

  logic [17:0] a_q, b_q;
  logic        a_oob_q, b_oob_q;
  logic [5:0]  w_q;
  logic [23:0] pix_q;
  logic [17:0] a_val, b_val;

  function automatic logic [7:0] blend(input logic [5:0] a, input logic [5:0] b,
                                       input logic [5:0] w);
    logic [11:0] p;
    p = 12'(a) * 12'(7'd64 - {1'b0, w}) + 12'(b) * 12'(w);
    return 8'(p >> 4);
  endfunction

  always_comb begin
    a_val = a_oob_q ? '0 : a_q;
    b_val = b_oob_q ? '0 : b_q;
  end

  always_ff @(posedge clk) begin
    if (enable) begin
      a_q     <= line_mem[{rd_bank, idx_q[8:0]}];
      b_q     <= line_mem[{rd_bank, idx_b[8:0]}];
      a_oob_q <= idx_q[9];
      b_oob_q <= idx_b[9];
      w_q     <= w_cur;
      pix_q   <= {blend(a_val[17:12], b_val[17:12], w_q),
                  blend(a_val[11:6],  b_val[11:6],  w_q),
                  blend(a_val[5:0],   b_val[5:0],   w_q)};
    end
  end

  // Valid tracking and output register
  logic        v0_q, v1_q;
  logic [23:0] video_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      video_q <= '0;
    end else if (enable) begin
      v0_q    <= issue;
      v1_q    <= v0_q;
      video_q <= v1_q ? pix_q : '0;
    end
  end

  assign video_r = video_q[23:16];
  assign video_g = video_q[15:8];
  assign video_b = video_q[7:0];

endmodule

// File: tb/tb_video_out_hmag.sv
// Directed line-by-line bench for video_out_hmag: drives full video lines and
// checks selected output pixels against hand values and a closed-form model.
module tb_video_out_hmag;

  localparam int SRC_START = 256;
  localparam int OUT_START = 200;
  localparam int OUT_WIDTH = 576;
  localparam int STEP      = 144;
  localparam int HTOTAL    = 1368;
  localparam int NLINES    = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [10:0] vdp_hcounter;
  logic [1:0]  vdp_vcounter;
  logic [5:0]  vdp_r, vdp_g, vdp_b;
  logic [7:0]  video_r, video_g, video_b;
  logic [7:0]  reg_left_offset, reg_denominator;
  logic [5:0]  reg_normalize;

  int n_tests = 0;
  int n_fail  = 0;

  // Per line: pattern written, registers used for reading the previous line
  int pat_wr [NLINES] = '{0, 0, 1, 2, 3, 4, 0, 0};
  int off_t  [NLINES] = '{0, 0, 0, 0, 112, 0, 0, 0};
  int den_t  [NLINES] = '{144, 144, 200, 200, 200, 144, 144, 144};
  int nrm_t  [NLINES] = '{56, 56, 40, 40, 40, 56, 56, 56};
  int mag_r  [5]      = '{2, 5, 8, 11, 14};

  video_out_hmag #(
    .SRC_START(SRC_START),
    .OUT_START(OUT_START),
    .OUT_WIDTH(OUT_WIDTH),
    .STEP(STEP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .vdp_hcounter(vdp_hcounter),
    .vdp_vcounter(vdp_vcounter),
    .vdp_r(vdp_r),
    .vdp_g(vdp_g),
    .vdp_b(vdp_b),
    .video_r(video_r),
    .video_g(video_g),
    .video_b(video_b),
    .reg_left_offset(reg_left_offset),
    .reg_denominator(reg_denominator),
    .reg_normalize(reg_normalize)
  );

  always #5 clk = ~clk;

  function automatic int src(input int ch, input int pat, input int x);
    int v;
    case (pat)
      0: begin
        if (ch == 0) return x % 64;
        if (ch == 1) return 63 - (x % 64);
        return (x * 3) % 64;
      end
      1: begin
        v = (((x / 12) % 2) == 0) ? 63 : 0;
        return (ch == 1) ? 63 - v : v;
      end
      2: return 63;
      3: return 21 + ch;
      default: return 42 - ch;
    endcase
  endfunction

  function automatic int model(input int ch, input int pat, input int off, input int den,
                               input int nrm, input int k);
    int pos, idx, frac, w, a, b;
    pos  = STEP * k;
    idx  = off + pos / den;
    frac = pos % den;
    w    = (frac * nrm) / 128;
    a    = (idx < 512) ? src(ch, pat, idx) : 0;
    b    = (idx + 1 < 512) ? src(ch, pat, idx + 1) : 0;
    return ((a * (64 - w) + b * w) / 16) % 256;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_rgb(input int ln, input int k);
    int rp;
    rp = pat_wr[ln - 1];
    check($sformatf("L%0d_k%0d_r", ln, k), int'(video_r), model(0, rp, off_t[ln], den_t[ln], nrm_t[ln], k));
    check($sformatf("L%0d_k%0d_g", ln, k), int'(video_g), model(1, rp, off_t[ln], den_t[ln], nrm_t[ln], k));
    check($sformatf("L%0d_k%0d_b", ln, k), int'(video_b), model(2, rp, off_t[ln], den_t[ln], nrm_t[ln], k));
  endtask

  task automatic check_zero(input int ln, input int h);
    check($sformatf("L%0d_h%0d_zero_r", ln, h), int'(video_r), 0);
    check($sformatf("L%0d_h%0d_zero_g", ln, h), int'(video_g), 0);
    check($sformatf("L%0d_h%0d_zero_b", ln, h), int'(video_b), 0);
  endtask

  task automatic drive(input int ln, input int h);
    int x;
    vdp_hcounter = 11'(h);
    vdp_vcounter = 2'(ln);
    enable       = (h % 2) == 0;
    reset        = (ln == 0 && h < 4) || (ln == 6 && h == 601);
    if (h == 0) begin
      reg_left_offset = 8'(off_t[ln]);
      reg_denominator = 8'(den_t[ln]);
      reg_normalize   = 6'(nrm_t[ln]);
    end
    // mid-line register change must not affect the current line
    if (ln == 4 && h == 400) begin
      reg_left_offset = 8'd0;
      reg_denominator = 8'd144;
      reg_normalize   = 6'd56;
    end
    if (h >= SRC_START && h < SRC_START + 1024) begin
      x     = (h - SRC_START) / 2;
      vdp_r = 6'(src(0, pat_wr[ln], x));
      vdp_g = 6'(src(1, pat_wr[ln], x));
      vdp_b = 6'(src(2, pat_wr[ln], x));
    end else begin
      vdp_r = '0;
      vdp_g = '0;
      vdp_b = '0;
    end
  endtask

  // h is the hcounter value sampled at the edge just taken
  task automatic checks(input int ln, input int h);
    bit kv;
    int k;
    kv = (h >= OUT_START + 4) && (((h - OUT_START - 4) % 2) == 0) &&
         ((h - OUT_START - 4) / 2 < OUT_WIDTH);
    k  = kv ? (h - OUT_START - 4) / 2 : -1;
    case (ln)
      0: if (h == 2) check_zero(ln, h);
      1: begin
        if (h == 100 || h == 202 || h == 1358) check_zero(ln, h);
        if (kv && k inside {0, 1, 37, 63, 64, 200, 511, 512}) begin
          check($sformatf("ident_k%0d", k), int'(video_r), (k < 512) ? (k % 64) * 4 : 0);
          check_rgb(ln, k);
        end
      end
      2: begin
        if (kv && k <= 40) check_rgb(ln, k);
        if (kv && k >= 1 && k <= 5) check($sformatf("mag_k%0d", k), int'(video_r), mag_r[k - 1]);
      end
      3: begin
        if (kv && k == 15) check("toggle_k15", int'(video_r), 252);
        if (kv && k == 16) check("toggle_k16_edge", int'(video_r), 126);
        if (kv && k == 17) check("toggle_k17", int'(video_r), 0);
        if (kv && k <= 60) check_rgb(ln, k);
        if (h == 1354) check("win_last", int'(video_r), 252);
        if (h == 1356) check("win_after", int'(video_r), 0);
      end
      4: if (kv && k inside {0, 554, 555, 556, 575}) begin
        check($sformatf("offset_k%0d", k), int'(video_r), (k <= 554) ? 252 : (k == 555) ? 106 : 0);
        check_rgb(ln, k);
      end
      5: if (kv && k inside {0, 300, 511, 512}) begin
        check($sformatf("bank_k%0d", k), int'(video_r), (k < 512) ? 84 : 0);
        check_rgb(ln, k);
      end
      6: begin
        if (kv && k == 148) check("pre_reset_k148", int'(video_r), 168);
        if (h == 601 || h == 602 || h == 800 || h == 1000) check_zero(ln, h);
      end
      7: if (kv && k inside {10, 511}) begin
        check($sformatf("post_reset_k%0d", k), int'(video_r), (k == 10) ? 40 : 252);
        check_rgb(ln, k);
      end
      default: ;
    endcase
  endtask

  initial begin
    for (int ln = 0; ln < NLINES; ln++) begin
      for (int h = 0; h < HTOTAL; h++) begin
        drive(ln, h);
        @(posedge clk);
        #1;
        checks(ln, h);
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
